// File: rtl/bias_add_requant_stage.sv
// Bias add + requantize stage between the layer adder tree and the activation buffer.
// Two-stage valid/ready pipeline: S1 adds bias (DW+1 bits), S2 rounds, shifts,
// saturates to OUT_W and optionally clamps negatives. Tags the last vector of each group.
// Optional feature macro: RELU_EN (negative saturated lanes forced to 0 in S2).
module bias_add_requant_stage #(
  parameter int unsigned N_adder_tree = 16,
  parameter int unsigned DW           = 18,
  parameter int unsigned OUT_W        = 8,
  parameter int unsigned SHIFT        = 8,
  parameter int unsigned GROUPS       = 34
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N_adder_tree*DW-1:0]    in_data,
  input  logic [N_adder_tree*DW-1:0]    bias,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [N_adder_tree*OUT_W-1:0] out_data,
  output logic                          out_last
);

  localparam int unsigned SW     = DW + 1;
  localparam int unsigned RW     = DW + 2;
  localparam int unsigned CW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int unsigned RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  // Rounding add needs one extra bit over the bias-add sum to avoid wrap at full scale
  localparam logic signed [RW-1:0] RND    = (SHIFT > 0) ? (RW'(1) << RND_SH) : '0;
  localparam logic signed [RW-1:0] SAT_HI = RW'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [RW-1:0] SAT_LO = ~SAT_HI;
  localparam logic [CW-1:0]        LAST_IDX = CW'(GROUPS - 1);

  logic                                s1_valid;
  logic                                s1_last;
  logic [N_adder_tree-1:0][SW-1:0]     s1_sum;
  logic [N_adder_tree-1:0][SW-1:0]     sum_c;
  logic [CW-1:0]                       grp_cnt;
  logic                                s2_ready_c;
  logic                                in_acc_c;
  logic [N_adder_tree*OUT_W-1:0]       rq_c;
  logic signed [RW-1:0]                rnd_v;
  logic signed [RW-1:0]                sh_v;
  logic signed [RW-1:0]                q_v;

  // S2 can load when empty or being drained this cycle; S1 can load when it can move on
  assign s2_ready_c = !out_valid || out_ready;
  assign in_ready   = !s1_valid || s2_ready_c;
  assign in_acc_c   = in_valid && in_ready;

  // Per-lane sign-extended bias add; DW+1 bits cannot overflow
  always_comb begin
    sum_c = '0;
    for (int i = 0; i < int'(N_adder_tree); i++) begin
      sum_c[i] = SW'($signed(in_data[DW*i +: DW])) + SW'($signed(bias[DW*i +: DW]));
    end
  end

  // Per-lane round-half-up, arithmetic shift, saturate, optional negative clamp
  always_comb begin
    rq_c  = '0;
    rnd_v = '0;
    sh_v  = '0;
    q_v   = '0;
    for (int i = 0; i < int'(N_adder_tree); i++) begin
      rnd_v = RW'($signed(s1_sum[i])) + RND;
      sh_v  = rnd_v >>> SHIFT;
      if (sh_v > SAT_HI) begin
        q_v = SAT_HI;
      end else if (sh_v < SAT_LO) begin
        q_v = SAT_LO;
      end else begin
        q_v = sh_v;
      end
`ifdef RELU_EN
      if (q_v[RW-1]) begin
        q_v = '0;
      end
`else
`endif
      rq_c[OUT_W*i +: OUT_W] = q_v[OUT_W-1:0];
    end
  end

  // S1: capture bias-added sums, group position tag and advance the group counter on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_sum   <= '0;
      grp_cnt  <= '0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
      end
      if (in_acc_c) begin
        s1_sum  <= sum_c;
        s1_last <= (grp_cnt == LAST_IDX);
        grp_cnt <= (grp_cnt == LAST_IDX) ? '0 : grp_cnt + CW'(1);
      end
    end
  end

  // S2: registered output; holds data and tag while stalled downstream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (s2_ready_c) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= rq_c;
        out_last <= s1_last;
      end
    end
  end

endmodule

// File: tb/tb_bias_add_requant_stage.sv
// Directed bench for bias_add_requant_stage: reset, arithmetic corner cases,
// backpressure streaming and group tagging, with an in-order scoreboard.
module tb_bias_add_requant_stage;

  localparam int N  = 16;
  localparam int DW = 18;
  localparam int OW = 8;
  localparam int SH = 8;
  localparam int G  = 34;
`ifdef RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [N*DW-1:0] in_data;
  logic [N*DW-1:0] bias;
  logic            out_valid;
  logic            out_ready;
  logic [N*OW-1:0] out_data;
  logic            out_last;

  bias_add_requant_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .bias      (bias),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int              checks;
  int              failures;
  int              acc_cnt;
  int              n_out;
  bit              stalled;
  logic [N*OW-1:0] held_data;
  logic            held_last;
  logic [N*OW-1:0] exp_q[$];
  bit              last_q[$];
  int              last_idx[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference: lane = clamp(floor((in + bias + 2^(SH-1)) / 2^SH))
  function automatic logic [N*OW-1:0] model(input logic [N*DW-1:0] d, input logic [N*DW-1:0] b);
    logic [N*OW-1:0] res;
    logic [DW-1:0]   dl;
    logic [DW-1:0]   bl;
    int              s;
    int              r;
    res = '0;
    for (int i = 0; i < N; i++) begin
      dl = d[i*DW +: DW];
      bl = b[i*DW +: DW];
      s  = int'($signed(dl)) + int'($signed(bl));
      r  = (s + (1 << (SH - 1))) >>> SH;
      if (r > 127) r = 127;
      if (r < -128) r = -128;
      if (RELU && r < 0) r = 0;
      res[i*OW +: OW] = OW'(r);
    end
    return res;
  endfunction

  function automatic logic [N*DW-1:0] rand_vec();
    logic [N*DW-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'($urandom);
    return v;
  endfunction

  // One clock: observe handshakes mid-low-phase, score outputs, then advance to next negedge
  task automatic tick();
    logic [N*OW-1:0] e;
    bit              el;
    #1;
    if (stalled) begin
      chk("stall_valid", 128'(out_valid), 128'(1));
      chk("stall_data", out_data, held_data);
      chk("stall_last", 128'(out_last), 128'(held_last));
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(model(in_data, bias));
      last_q.push_back((acc_cnt % G) == G - 1);
      acc_cnt++;
    end
    if (out_valid && out_ready) begin
      chk("out_expected", 128'(exp_q.size() != 0), 128'(1));
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        el = last_q.pop_front();
        chk("out_data", out_data, e);
        chk("out_last", 128'(out_last), 128'(el));
      end
      if (out_last) last_idx.push_back(n_out);
      n_out++;
    end
    stalled   = out_valid && !out_ready;
    held_data = out_data;
    held_last = out_last;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic directed(input string tag, input logic [N*DW-1:0] d, input logic [N*DW-1:0] b,
                          input logic [N*OW-1:0] hand);
    in_data   = d;
    bias      = b;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    in_data  = '0;
    chk({tag, "_lat1_valid"}, 128'(out_valid), 128'(0));
    tick();
    chk({tag, "_lat2_valid"}, 128'(out_valid), 128'(1));
    chk({tag, "_data"}, out_data, hand);
    chk({tag, "_last"}, 128'(out_last), 128'(0));
    tick();
  endtask

  task automatic drain(input string tag);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
    chk({tag, "_drain_empty"}, 128'(exp_q.size()), 128'(0));
    chk({tag, "_drain_valid"}, 128'(out_valid), 128'(0));
  endtask

  initial begin
    logic [N*DW-1:0] d;
    logic [N*DW-1:0] b;
    logic [N*OW-1:0] h;
    int              cyc;
    int              start;
    checks    = 0;
    failures  = 0;
    acc_cnt   = 0;
    n_out     = 0;
    stalled   = 1'b0;
    held_data = '0;
    held_last = 1'b0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    bias      = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_data", out_data, '0);
    chk("rst_out_last", 128'(out_last), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    rst_n = 1'b1;
    @(negedge clk);

    // 1024 + 256 -> 5 ; -1024 -> -4
    d = '0; b = '0; h = '0;
    d[0 +: DW]  = 18'h00400;
    d[DW +: DW] = 18'h3FC00;
    b[0 +: DW]  = 18'h00100;
    h[7:0]      = 8'h05;
    h[15:8]     = RELU ? 8'h00 : 8'hFC;
    directed("basic", d, b, h);

    // Full-scale positive and negative saturation
    d = '0; b = '0; h = '0;
    d[0 +: DW]  = 18'h1FFFF;
    b[0 +: DW]  = 18'h1FFFF;
    d[DW +: DW] = 18'h20000;
    b[DW +: DW] = 18'h20000;
    h[7:0]      = 8'h7F;
    h[15:8]     = RELU ? 8'h00 : 8'h80;
    directed("sat", d, b, h);

    // Rounding: 384 -> 2, -384 -> -1, 127 -> 0
    d = '0; b = '0; h = '0;
    d[0 +: DW]    = 18'h00180;
    d[DW +: DW]   = 18'h3FE80;
    d[2*DW +: DW] = 18'h0007F;
    h[7:0]        = 8'h02;
    h[15:8]       = RELU ? 8'h00 : 8'hFF;
    h[23:16]      = 8'h00;
    directed("round", d, b, h);

    // Fill both stages under backpressure, then reset mid-stream
    bias      = rand_vec();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data = rand_vec();
      tick();
    end
    chk("pre_rst_full", 128'(out_valid), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 128'(out_valid), 128'(0));
    chk("midrst_out_data", out_data, '0);
    chk("midrst_out_last", 128'(out_last), 128'(0));
    chk("midrst_in_ready", 128'(in_ready), 128'(1));
    exp_q.delete();
    last_q.delete();
    last_idx.delete();
    acc_cnt  = 0;
    n_out    = 0;
    stalled  = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 128'(in_ready), 128'(1));

    // Group tagging over two full groups at full rate
    bias      = rand_vec();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    cyc       = 0;
    while (acc_cnt < 2 * G && cyc < 300) begin
      in_data = rand_vec();
      tick();
      cyc++;
    end
    drain("group");
    chk("group_accepted", 128'(acc_cnt), 128'(2 * G));
    chk("group_outputs", 128'(n_out), 128'(2 * G));
    chk("group_last_count", 128'(last_idx.size()), 128'(2));
    if (last_idx.size() == 2) begin
      chk("group_last_idx0", 128'(last_idx[0]), 128'(G - 1));
      chk("group_last_idx1", 128'(last_idx[1]), 128'(2 * G - 1));
    end

    // Random valid/ready streaming of 40 vectors
    bias  = rand_vec();
    start = acc_cnt;
    cyc   = 0;
    while (acc_cnt - start < 40 && cyc < 1000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 1));
      in_data   = rand_vec();
      tick();
      cyc++;
    end
    drain("bp");
    chk("bp_accepted", 128'(acc_cnt - start), 128'(40));
    chk("bp_outputs", 128'(n_out), 128'(2 * G + 40));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
